// File: rtl/stack_unit.sv
// LIFO operand stack for the stack-machine datapath with registered top-of-stack.
// Optional STACK_BYPASS_EN forwards push data / post-pop top into dout.
module stack_unit #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             tos,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [PTR_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             udf
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_sp;
   logic [WIDTH-1:0] r_dout;
   logic             r_ovf;
   logic             r_udf;

   logic             w_empty;
   logic             w_full;
   logic             w_rep;
   logic             w_wr;
   logic             w_pop_ok;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_top_idx;
   logic [AW-1:0]    w_sec_idx;
   logic [WIDTH-1:0] w_top;
   logic [WIDTH-1:0] w_sec;
   logic [WIDTH-1:0] w_dout_nxt;

   assign w_empty   = (r_sp == '0);
   assign w_full    = (r_sp == PTR_W'(DEPTH));
   assign w_wr_idx  = r_sp[AW-1:0];
   assign w_top_idx = r_sp[AW-1:0] - AW'(1);
   assign w_sec_idx = r_sp[AW-1:0] - AW'(2);
   assign w_top     = r_mem[w_top_idx];
   assign w_sec     = r_mem[w_sec_idx];

   // push+pop on a non-empty stack overwrites the top, even when full
   assign w_rep    = push & pop & ~w_empty;
   assign w_wr     = push & ~w_rep & ~w_full;
   assign w_pop_ok = pop & ~push & ~w_empty;

   always_comb begin
      w_dout_nxt = w_empty ? '0 : w_top;
`ifdef STACK_BYPASS_EN
      if (w_wr || w_rep)
         w_dout_nxt = din;
      else if (pop && !push)
         w_dout_nxt = (w_empty || r_sp == PTR_W'(1)) ? '0 : w_sec;
`endif
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[w_wr_idx] <= din;
      else if (w_rep)
         r_mem[w_top_idx] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sp   <= '0;
         r_dout <= '0;
         r_ovf  <= 1'b0;
         r_udf  <= 1'b0;
      end else begin
         if (w_wr)
            r_sp <= r_sp + PTR_W'(1);
         else if (w_pop_ok)
            r_sp <= r_sp - PTR_W'(1);
         if (tos)
            r_dout <= w_dout_nxt;
         if (push && !pop && w_full)
            r_ovf <= 1'b1;
         if ((pop || tos) && w_empty)
            r_udf <= 1'b1;
      end
   end

   assign dout  = r_dout;
   assign count = r_sp;
   assign empty = w_empty;
   assign full  = w_full;
   assign ovf   = r_ovf;
   assign udf   = r_udf;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit at DEPTH=4.
// Expected values follow STACK_BYPASS_EN when the macro is defined.
module tb_stack_unit;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int PTR_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic             tos = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] dout;
   logic [PTR_W-1:0] count;
   logic             empty;
   logic             full;
   logic             ovf;
   logic             udf;

   int n_chk  = 0;
   int n_fail = 0;

   stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos),
      .din(din), .dout(dout), .count(count), .empty(empty),
      .full(full), .ovf(ovf), .udf(udf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic p, input logic q, input logic t,
                      input logic [WIDTH-1:0] d);
      push = p; pop = q; tos = t; din = d;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; tos = 1'b0; din = '0;
   endtask

   task automatic rst_pulse();
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   initial begin
      #3;
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_dout", 32'(dout), 0);
      check("rst_flags", {30'd0, ovf, udf}, 0);
      @(negedge clk);
      rst = 1'b1;

      // async reset mid-operation
      cyc(1, 0, 0, 8'hA1);
      cyc(1, 0, 1, 8'hA2);
`ifdef STACK_BYPASS_EN
      check("pre_rst_dout", 32'(dout), 32'hA2);
`else
      check("pre_rst_dout", 32'(dout), 32'hA1);
`endif
      check("pre_rst_count", 32'(count), 2);
      #1;
      rst = 1'b0;
      #1;
      check("async_count", 32'(count), 0);
      check("async_empty", 32'(empty), 1);
      check("async_dout", 32'(dout), 0);
      check("async_flags", {30'd0, ovf, udf}, 0);
      @(negedge clk);
      rst = 1'b1;

      // basic push / tos / pop
      cyc(1, 0, 0, 8'h11);
      cyc(1, 0, 0, 8'h22);
      cyc(1, 0, 0, 8'h33);
      cyc(0, 0, 1, 8'h00);
      check("tos_33", 32'(dout), 32'h33);
      check("count_3", 32'(count), 3);
      cyc(0, 1, 0, 8'h00);
      cyc(0, 0, 1, 8'h00);
      check("tos_22", 32'(dout), 32'h22);
      check("count_2", 32'(count), 2);
      cyc(0, 0, 0, 8'h00);
      check("dout_hold", 32'(dout), 32'h22);

      // tos+push on top 0x22
      cyc(1, 0, 1, 8'h77);
`ifdef STACK_BYPASS_EN
      check("tos_push", 32'(dout), 32'h77);
`else
      check("tos_push", 32'(dout), 32'h22);
`endif
      check("tos_push_cnt", 32'(count), 3);
      cyc(0, 1, 0, 8'h00);
      // tos+pop with {0x11,0x22}
      cyc(0, 1, 1, 8'h00);
`ifdef STACK_BYPASS_EN
      check("tos_pop", 32'(dout), 32'h11);
`else
      check("tos_pop", 32'(dout), 32'h22);
`endif
      check("tos_pop_cnt", 32'(count), 1);

      // replace-top
      cyc(1, 0, 0, 8'h22);
      cyc(1, 1, 0, 8'h99);
      check("rep_count", 32'(count), 2);
      check("rep_flags", {30'd0, ovf, udf}, 0);
      cyc(0, 0, 1, 8'h00);
      check("rep_tos", 32'(dout), 32'h99);

      // underflow
      cyc(0, 1, 0, 8'h00);
      cyc(0, 1, 0, 8'h00);
      check("drain_empty", 32'(empty), 1);
      check("drain_udf", 32'(udf), 0);
      cyc(0, 1, 0, 8'h00);
      check("udf_pop", 32'(udf), 1);
      check("udf_count", 32'(count), 0);
      cyc(0, 0, 1, 8'h00);
      check("udf_tos_dout", 32'(dout), 0);
      check("udf_sticky", 32'(udf), 1);
      cyc(1, 0, 0, 8'h5A);
      check("udf_no_block", 32'(count), 1);

      // push+pop on empty
      rst_pulse();
      check("rst2_udf", 32'(udf), 0);
      cyc(1, 1, 0, 8'h44);
      check("pp_empty_cnt", 32'(count), 1);
      check("pp_empty_udf", 32'(udf), 1);
      cyc(0, 0, 1, 8'h00);
      check("pp_empty_tos", 32'(dout), 32'h44);

      // overflow
      rst_pulse();
      cyc(1, 0, 0, 8'h01);
      cyc(1, 0, 0, 8'h02);
      cyc(1, 0, 0, 8'h03);
      cyc(1, 0, 0, 8'h04);
      check("full_flag", 32'(full), 1);
      check("full_ovf0", 32'(ovf), 0);
      cyc(1, 0, 0, 8'h55);
      check("ovf_full", 32'(full), 1);
      check("ovf_count", 32'(count), 4);
      check("ovf_set", 32'(ovf), 1);
      cyc(0, 1, 0, 8'h00);
      cyc(0, 0, 1, 8'h00);
      check("ovf_tos3", 32'(dout), 32'h03);
      check("ovf_cnt3", 32'(count), 3);
      cyc(1, 0, 0, 8'h66);
      check("ovf_no_block", 32'(count), 4);
      cyc(1, 0, 1, 8'h88);
      check("full_tos_push", 32'(dout), 32'h66);
      check("full_cnt", 32'(count), 4);
      cyc(1, 1, 0, 8'hBB);
      check("full_rep_cnt", 32'(count), 4);
      cyc(0, 0, 1, 8'h00);
      check("full_rep_tos", 32'(dout), 32'hBB);
      check("ovf_sticky", 32'(ovf), 1);
      check("full_udf", 32'(udf), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware LIFO stack driven by the multicycle stack-machine controller's push/pop/tos strobes.
- Responder side of the controller's stack interface: holds operands and delivers the registered top-of-stack value to the datapath A/B operand registers.
- Flags overflow and underflow, and reports occupancy.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of stack entries (power of two, >= 2).
- PTR_W, $clog2(DEPTH)+1, width of the stack pointer and count.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous active-low reset.
- push  input  1  write din onto stack this cycle.
- pop  input  1  remove top entry this cycle.
- tos  input  1  capture current top entry into dout this cycle.
- din  input  WIDTH  data to push (datapath MtoS mux output).
- dout  output  WIDTH  registered top-of-stack value.
- count  output  PTR_W  number of valid entries, 0..DEPTH.
- empty  output  1  count==0, combinational from count.
- full  output  1  count==DEPTH, combinational from count.
- ovf  output  1  sticky overflow flag.
- udf  output  1  sticky underflow flag.

Behaviour:
- Reset (rst low, async): sp=0, count=0, dout=0, ovf=0, udf=0. Storage array contents are not reset. All outputs are valid on the first edge after rst deasserts.
- Storage: mem[0..DEPTH-1]; sp points to the next free slot; the top entry is mem[sp-1].
- Push only: if !full, mem[sp]<=din and sp<=sp+1 on the edge. If full, the write is dropped, sp is unchanged, and ovf<=1.
- Pop only: if !empty, sp<=sp-1; the popped data is not driven anywhere. If empty, the pop is ignored and udf<=1.
- Push and pop in the same cycle:
  - Not empty: replace-top. mem[sp-1]<=din, sp is unchanged, no flag is set; this also holds when full.
  - Empty: the pop is ignored with udf<=1, and the push proceeds normally (sp becomes 1).
- tos:
  - dout<=mem[sp-1] on the edge, using the pre-edge sp and contents.
  - 1-cycle latency: the value is visible the cycle after tos, matching the controller loading A/B in the following state.
  - tos while empty: dout<=0 and udf<=1.
  - When tos is low, dout holds its value.
- tos with pop or push same cycle: dout takes the pre-edge top, except as modified by STACK_BYPASS_EN.
- ovf and udf are sticky until reset; they never block later legal operations.
- No internal FSM beyond the pointer. All operations are single-cycle and the block accepts one command set per clock with no back-pressure.
- Pointer arithmetic is modulo 2^PTR_W, but guarded: sp never exceeds DEPTH and never wraps below 0.

Optional Feature:
- Macro: STACK_BYPASS_EN.
- Defined: forwarding path. When tos and push are asserted together and the push is accepted (or is a replace-top), dout<=din.
- Defined, with tos+pop and no push: dout<=mem[sp-2], the new top after the pop; if sp==1, dout<=0.
- Undefined: dout always reflects the pre-edge top as specified above.

Test Plan:
- DEPTH=4 build. Reset low mid-operation after 2 pushes -> count=0, empty=1, dout=0, ovf=udf=0 immediately, without waiting for a clock edge.
- Push 0x11,0x22,0x33; tos -> next cycle dout=0x33, count=3. Pop; tos -> dout=0x22, count=2.
- Push 4 values, then push 0x55 -> full=1, count=4, ovf=1. Pop and tos -> dout equals the 3rd pushed value, not 0x55.
- From empty: pop -> udf=1, count=0. Then tos -> dout=0, udf stays 1.
- count=2 with top 0x22: push=pop=1, din=0x99 -> count=2; a later tos gives 0x99. Empty with push=pop=1, din=0x44 -> count=1, udf=1.
- tos+push din=0x77 on top 0x22 -> dout=0x22 without STACK_BYPASS_EN, 0x77 with it. tos+pop with stack {0x11,0x22} -> 0x22 without the macro, 0x11 with it.
